// File: rtl/snake_input_ctrl_pkg.sv
// snake_input_ctrl_pkg: shared definitions for the snake input conditioning block.
//   - direction encoding and its opposite() helper
//   - default debounce length and counter width
//   - button index order used for the per-button vectors in the top
package snake_input_ctrl_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_e;

  // 10 ms at 100 MHz
  localparam int unsigned DB_CYCLES_DEF = 1000000;
  localparam int unsigned CNT_W_DEF     = 20;

  localparam int unsigned N_BTN = 5;
  localparam int unsigned BTN_L = 0;
  localparam int unsigned BTN_R = 1;
  localparam int unsigned BTN_U = 2;
  localparam int unsigned BTN_D = 3;
  localparam int unsigned BTN_C = 4;

  // UP<->DOWN and LEFT<->RIGHT differ only in bit 0
  function automatic dir_e opposite(input dir_e d);
    return dir_e'({d[1], ~d[0]});
  endfunction

endpackage

// File: rtl/snake_debounce.sv
// snake_debounce: 2-FF synchroniser, stable-count debouncer and press one-shot.
// Ports:
//   Clk    in  board clock
//   Reset  in  asynchronous active-high reset
//   Raw    in  raw button, asynchronous to Clk
//   Level  out debounced level
//   Pulse  out one-cycle pulse the cycle after Level rises
module snake_debounce
  import snake_input_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Raw,
  output logic Level,
  output logic Pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_q;
  logic             r_pulse;
  logic [CNT_W-1:0] r_cnt;

  // Synchroniser, debounce counter and rising-edge one-shot
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_q <= 1'b0;
      r_pulse   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync1   <= Raw;
      r_sync2   <= r_sync1;
      r_level_q <= r_level;
      r_pulse   <= r_level & ~r_level_q;
      // Any sample agreeing with the stable level restarts the count
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign Level = r_level;
  assign Pulse = r_pulse;

endmodule

// File: rtl/snake_input_ctrl.sv
// snake_input_ctrl: button conditioning and direction arbitration for snake_core.
// Ports:
//   Clk, Reset                      board clock, asynchronous active-high reset
//   BtnL/BtnR/BtnU/BtnD/BtnC        raw push-buttons
//   Tick                            one-cycle game-step strobe
//   LeftP/RightP/UpP/DownP/AckP     one-cycle debounced press pulses
//   Dir                             committed direction for this step
//   Pending                         direction committed at the next Tick
//   DirValid                        one-cycle pulse after each Tick
module snake_input_ctrl
  import snake_input_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       BtnL,
  input  logic       BtnR,
  input  logic       BtnU,
  input  logic       BtnD,
  input  logic       BtnC,
  input  logic       Tick,
  output logic       LeftP,
  output logic       RightP,
  output logic       UpP,
  output logic       DownP,
  output logic       AckP,
  output logic [1:0] Dir,
  output logic [1:0] Pending,
  output logic       DirValid
);

  logic [N_BTN-1:0] w_raw;
  logic [N_BTN-1:0] w_pulse;
  // Debounced levels are not needed past the one-shots
  logic [N_BTN-1:0] w_level_unused;

  // Bit order follows the BTN_* indices
  assign w_raw = {BtnC, BtnD, BtnU, BtnR, BtnL};

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    snake_debounce #(
      .DB_CYCLES(DB_CYCLES),
      .CNT_W    (CNT_W)
    ) u_db (
      .Clk  (Clk),
      .Reset(Reset),
      .Raw  (w_raw[g]),
      .Level(w_level_unused[g]),
      .Pulse(w_pulse[g])
    );
  end

  dir_e r_dir;
  dir_e r_pend;
  logic r_dir_valid;

  dir_e w_req;
  dir_e w_dir_next;
  logic w_any;
  logic w_legal;

  // Priority pick UP > DOWN > LEFT > RIGHT, judged against the direction in force next step
  always_comb begin
    w_req      = DIR_UP;
    w_any      = 1'b1;
    w_dir_next = Tick ? r_pend : r_dir;
    if (w_pulse[BTN_U]) begin
      w_req = DIR_UP;
    end else if (w_pulse[BTN_D]) begin
      w_req = DIR_DOWN;
    end else if (w_pulse[BTN_L]) begin
      w_req = DIR_LEFT;
    end else if (w_pulse[BTN_R]) begin
      w_req = DIR_RIGHT;
    end else begin
      w_any = 1'b0;
    end
    w_legal = w_any && (w_req != opposite(w_dir_next));
  end

  // Pending / Dir / DirValid registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_dir       <= DIR_RIGHT;
      r_pend      <= DIR_RIGHT;
      r_dir_valid <= 1'b0;
    end else begin
      r_dir_valid <= Tick;
      if (Tick) begin
        r_dir <= r_pend;
      end
      if (w_legal) begin
        r_pend <= w_req;
      end
    end
  end

  assign LeftP    = w_pulse[BTN_L];
  assign RightP   = w_pulse[BTN_R];
  assign UpP      = w_pulse[BTN_U];
  assign DownP    = w_pulse[BTN_D];
  assign AckP     = w_pulse[BTN_C];
  assign Dir      = r_dir;
  assign Pending  = r_pend;
  assign DirValid = r_dir_valid;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// tb_snake_input_ctrl: directed, table-driven and random checks of snake_input_ctrl
// against a window-based behavioural model (DB_CYCLES=4, CNT_W=3).
module tb_snake_input_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned CW = 3;
  localparam int unsigned HL = DB + 2;

  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3;

  // button mask bits: L=0 R=1 U=2 D=3 C=4
  localparam logic [4:0] ML = 5'b00001;
  localparam logic [4:0] MR = 5'b00010;
  localparam logic [4:0] MU = 5'b00100;
  localparam logic [4:0] MD = 5'b01000;
  localparam logic [4:0] MC = 5'b10000;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [4:0] btn;

  logic       l_p, r_p, u_p, d_p, a_p;
  logic [1:0] dir, pend;
  logic       dv;
  logic [4:0] pv;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int rp_cnt = 0;

  always #5 clk = ~clk;

  snake_input_ctrl #(.DB_CYCLES(DB), .CNT_W(CW)) dut (
    .Clk(clk), .Reset(rst),
    .BtnL(btn[0]), .BtnR(btn[1]), .BtnU(btn[2]), .BtnD(btn[3]), .BtnC(btn[4]),
    .Tick(tick),
    .LeftP(l_p), .RightP(r_p), .UpP(u_p), .DownP(d_p), .AckP(a_p),
    .Dir(dir), .Pending(pend), .DirValid(dv)
  );

  assign pv = {a_p, d_p, u_p, r_p, l_p};

  // ---------------- reference model ----------------
  // A level flips once the last DB synchronised samples (raw delayed by 2) all differ from it.
  bit m_hist [5][HL];
  bit m_lvl  [5];
  bit m_rose [5];
  bit m_pls  [5];
  int m_dir, m_pend, m_req, m_ref;
  bit m_dv, m_stable;

  function automatic int opp(input int d);
    case (d)
      UP:      return DOWN;
      DOWN:    return UP;
      LEFT:    return RIGHT;
      default: return LEFT;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 5; b++) begin
        for (int i = 0; i < int'(HL); i++) m_hist[b][i] = 1'b0;
        m_lvl[b] = 1'b0; m_rose[b] = 1'b0; m_pls[b] = 1'b0;
      end
      m_dir = RIGHT; m_pend = RIGHT; m_dv = 1'b0;
    end else begin
      m_req = -1;
      if (m_pls[2]) m_req = UP;
      else if (m_pls[3]) m_req = DOWN;
      else if (m_pls[0]) m_req = LEFT;
      else if (m_pls[1]) m_req = RIGHT;
      m_ref = tick ? m_pend : m_dir;
      m_dv  = tick;
      if (tick) m_dir = m_pend;
      if (m_req >= 0 && m_req != opp(m_ref)) m_pend = m_req;
      for (int b = 0; b < 5; b++) begin
        for (int i = int'(HL) - 1; i > 0; i--) m_hist[b][i] = m_hist[b][i-1];
        m_hist[b][0] = btn[b];
        m_pls[b] = m_rose[b];
        m_stable = 1'b1;
        for (int i = 2; i < int'(HL); i++) if (m_hist[b][i] == m_lvl[b]) m_stable = 1'b0;
        m_rose[b] = m_stable && !m_lvl[b];
        if (m_stable) m_lvl[b] = !m_lvl[b];
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic [9:0] exp_v, act_v;
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      exp_v = {m_pls[0], m_pls[1], m_pls[2], m_pls[3], m_pls[4], 2'(m_dir), 2'(m_pend), m_dv};
      act_v = {l_p, r_p, u_p, d_p, a_p, dir, pend, dv};
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_cycle t=%0t got=%b expected=%b", $time, act_v, exp_v);
      end
    end
    if (r_p === 1'b1) rp_cnt++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; btn = '0; tick = 1'b0;
    cycles(2);
    rst = 1'b0;
    cycles(1);
  endtask

  // Posedges counted from the drive point until the pulse is seen; -1 if it never arrives
  task automatic wait_pulse(input int b, output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #2;
      if (pv[b] === 1'b1) begin n = i; break; end
    end
  endtask

  task automatic press(input logic [4:0] m);
    @(negedge clk); btn = btn | m;
    cycles(10);
    btn = btn & ~m;
    cycles(int'(DB) + 4);
  endtask

  task automatic pulse_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    cycles(1);
  endtask

  typedef struct {
    logic [4:0] a;
    bit         a_tick;
    logic [4:0] b;
    bit         b_tick;
    logic [1:0] exp_dir;
    logic [1:0] exp_pend;
  } vec_t;

  vec_t tbl [10];
  int   n;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; btn = '0; tick = 1'b0;
    tbl[0] = '{5'b0, 1'b0, ML,      1'b0, 2'b11, 2'b11};
    tbl[1] = '{5'b0, 1'b0, MD,      1'b0, 2'b11, 2'b01};
    tbl[2] = '{MU,   1'b1, MD,      1'b0, 2'b00, 2'b00};
    tbl[3] = '{MU,   1'b1, ML,      1'b0, 2'b00, 2'b10};
    tbl[4] = '{MU,   1'b0, MD,      1'b1, 2'b00, 2'b00};
    tbl[5] = '{5'b0, 1'b0, MU | ML, 1'b0, 2'b11, 2'b00};
    tbl[6] = '{5'b0, 1'b0, MC,      1'b0, 2'b11, 2'b11};
    tbl[7] = '{MD,   1'b0, ML,      1'b1, 2'b01, 2'b10};
    tbl[8] = '{MU,   1'b1, MD | MR, 1'b0, 2'b00, 2'b00};
    tbl[9] = '{5'b0, 1'b0, MR,      1'b0, 2'b11, 2'b11};

    do_reset();
    chk_en = 1'b1;

    // reset state after idle
    cycles(20);
    check("idle_dir", 32'(dir), 32'h3);
    check("idle_pending", 32'(pend), 32'h3);
    check("idle_pulses", 32'(pv), 32'h0);
    check("idle_dirvalid", 32'(dv), 32'h0);

    // UP press latency, single pulse, pending and tick commit
    @(negedge clk); btn[2] = 1'b1;
    wait_pulse(2, n);
    check("upp_latency", 32'(n), 32'd7);
    @(posedge clk); #2;
    check("upp_one_cycle", 32'(u_p), 32'h0);
    check("pend_up", 32'(pend), 32'h0);
    cycles(10);
    check("upp_held_no_repeat", 32'(pv), 32'h0);
    btn[2] = 1'b0;
    cycles(int'(DB) + 4);
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    check("dir_after_tick", 32'(dir), 32'h0);
    check("dirvalid_after_tick", 32'(dv), 32'h1);
    @(negedge clk);
    check("dirvalid_one_cycle", 32'(dv), 32'h0);

    // table of direction-arbitration scenarios
    for (int t = 0; t < 10; t++) begin
      do_reset();
      if (tbl[t].a != 5'b0) begin
        press(tbl[t].a);
        if (tbl[t].a_tick) pulse_tick();
      end
      if (!tbl[t].b_tick) begin
        press(tbl[t].b);
      end else begin
        @(negedge clk); btn = btn | tbl[t].b;
        cycles(7);
        tick = 1'b1;
        @(negedge clk); tick = 1'b0;
        btn = btn & ~tbl[t].b;
        cycles(int'(DB) + 4);
      end
      check($sformatf("tbl%0d_dir", t), 32'(dir), 32'(tbl[t].exp_dir));
      check($sformatf("tbl%0d_pend", t), 32'(pend), 32'(tbl[t].exp_pend));
    end

    // bouncing right button, then held
    do_reset();
    rp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); btn[1] = (i % 2 == 0);
      cycles(1);
    end
    @(negedge clk); btn[1] = 1'b1;
    wait_pulse(1, n);
    check("bounce_latency", 32'(n), 32'd7);
    cycles(12);
    check("bounce_single_pulse", 32'(rp_cnt), 32'd1);
    btn[1] = 1'b0;
    cycles(int'(DB) + 4);

    // reset mid-debounce with Pending=DOWN, button held through reset
    do_reset();
    press(MD);
    check("pre_reset_pend", 32'(pend), 32'h1);
    @(negedge clk); btn[0] = 1'b1;
    cycles(5);
    rst = 1'b1;
    @(posedge clk); #1;
    check("reset_outputs", 32'({l_p, r_p, u_p, d_p, a_p, dir, pend, dv}), 32'({5'b0, 2'b11, 2'b11, 1'b0}));
    @(negedge clk); rst = 1'b0;
    wait_pulse(0, n);
    check("held_through_reset", 32'(n), 32'd7);
    btn[0] = 1'b0;
    cycles(int'(DB) + 4);

    // random buttons, ticks and occasional resets against the model
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (rst) rst = 1'b0;
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 7) == 0) btn[b] = ~btn[b];
      tick = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
    end
    @(negedge clk); rst = 1'b0; tick = 1'b0; btn = '0;
    cycles(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
